// File: rtl/fp16_to_fixed_if.sv
// Operand/result bundle for the binary16 to fixed-point converter.
// No latency of its own; it only groups the start/done pulse handshake signals.
// No backpressure: start is ignored while the converter is busy.
interface fp16_to_fixed_if #(
    parameter int N = 32
);
    logic [15:0]  float_in;
    logic         start;
    logic [N-1:0] fixed_out;
    logic         done;
    logic         busy;
    logic         overflow;
    logic         invalid;

    // Requester side: drives the operand and start, observes the result.
    modport master (
        output float_in,
        output start,
        input  fixed_out,
        input  done,
        input  busy,
        input  overflow,
        input  invalid
    );

    // Converter side.
    modport slave (
        input  float_in,
        input  start,
        output fixed_out,
        output done,
        output busy,
        output overflow,
        output invalid
    );
endinterface

// File: rtl/fp16_to_fixed.sv
// Converts IEEE binary16 to signed Q-fractional N-bit fixed point, saturating on overflow.
// Latency: 2 edges from start accept to done for specials/shortcuts, 2+|k| edges when shifting.
// No backpressure: start is accepted only in IDLE; a start while busy is dropped.
module fp16_to_fixed #(
    parameter int N = 32,
    parameter int Q = 23
) (
    input  logic               clk,
    input  logic               rst_n,
    fp16_to_fixed_if.slave     bus
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_CLASSIFY = 2'd1,
        S_SHIFT    = 2'd2,
        S_RESULT   = 2'd3
    } state_t;

    localparam logic signed [7:0] KQ      = 8'(Q);
    // A normal input overflows once its leading one would land on or above the sign bit.
    localparam logic signed [7:0] K_LIMIT = 8'(N - 11);

    state_t       r_state;
    logic [15:0]  r_float;
    logic [N-1:0] r_acc;
    logic [7:0]   r_cnt;
    logic         r_dir_left;
    logic         r_ovf_pend;
    logic         r_inv_pend;
    logic [N-1:0] r_fixed;
    logic         r_done;
    logic         r_ovf;
    logic         r_inv;

    state_t       w_nxt_state;
    logic [15:0]  w_nxt_float;
    logic [N-1:0] w_nxt_acc;
    logic [7:0]   w_nxt_cnt;
    logic         w_nxt_dir_left;
    logic         w_nxt_ovf_pend;
    logic         w_nxt_inv_pend;
    logic [N-1:0] w_nxt_fixed;
    logic         w_nxt_done;
    logic         w_nxt_ovf;
    logic         w_nxt_inv;

    // Field decode of the captured operand.
    logic              w_sign;
    logic [4:0]        w_exp;
    logic [9:0]        w_man;
    logic [4:0]        w_exp_eff;
    logic [10:0]       w_mant;
    logic [N-1:0]      w_mant_ext;
    logic signed [7:0] w_k;
    logic [7:0]        w_abs_k;
    logic              w_is_nan;
    logic              w_is_inf;
    logic              w_is_zero;
    logic              w_is_normal;
    logic [N-1:0]      w_sat_mag;

    assign w_sign      = r_float[15];
    assign w_exp       = r_float[14:10];
    assign w_man       = r_float[9:0];
    assign w_is_nan    = (w_exp == 5'h1F) && (w_man != 10'd0);
    assign w_is_inf    = (w_exp == 5'h1F) && (w_man == 10'd0);
    assign w_is_zero   = (w_exp == 5'h00) && (w_man == 10'd0);
    assign w_is_normal = (w_exp != 5'h00) && (w_exp != 5'h1F);
    // Subnormals share the minimum exponent but have no hidden one.
    assign w_exp_eff   = (w_exp == 5'h00) ? 5'd1 : w_exp;
    assign w_mant      = {(w_exp != 5'h00), w_man};
    assign w_mant_ext  = {{(N-11){1'b0}}, w_mant};
    assign w_k         = $signed({3'b000, w_exp_eff}) - 8'sd25 + KQ;
    assign w_abs_k     = w_k[7] ? $unsigned(-w_k) : $unsigned(w_k);
    // Held as a magnitude so the common negate in RESULT yields -2^(N-1) for negative saturation.
    assign w_sat_mag   = w_sign ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};

    // State and datapath registers; reset discards any conversion in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_float    <= 16'd0;
            r_acc      <= '0;
            r_cnt      <= 8'd0;
            r_dir_left <= 1'b0;
            r_ovf_pend <= 1'b0;
            r_inv_pend <= 1'b0;
            r_fixed    <= '0;
            r_done     <= 1'b0;
            r_ovf      <= 1'b0;
            r_inv      <= 1'b0;
        end else begin
            r_state    <= w_nxt_state;
            r_float    <= w_nxt_float;
            r_acc      <= w_nxt_acc;
            r_cnt      <= w_nxt_cnt;
            r_dir_left <= w_nxt_dir_left;
            r_ovf_pend <= w_nxt_ovf_pend;
            r_inv_pend <= w_nxt_inv_pend;
            r_fixed    <= w_nxt_fixed;
            r_done     <= w_nxt_done;
            r_ovf      <= w_nxt_ovf;
            r_inv      <= w_nxt_inv;
        end
    end

    // Next-state and datapath updates: classify once, then shift one bit per cycle.
    always_comb begin
        w_nxt_state    = r_state;
        w_nxt_float    = r_float;
        w_nxt_acc      = r_acc;
        w_nxt_cnt      = r_cnt;
        w_nxt_dir_left = r_dir_left;
        w_nxt_ovf_pend = r_ovf_pend;
        w_nxt_inv_pend = r_inv_pend;
        w_nxt_fixed    = r_fixed;
        w_nxt_done     = 1'b0;
        w_nxt_ovf      = r_ovf;
        w_nxt_inv      = r_inv;

        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_nxt_float = bus.float_in;
                    w_nxt_state = S_CLASSIFY;
                end
            end
            S_CLASSIFY: begin
                w_nxt_ovf_pend = 1'b0;
                w_nxt_inv_pend = 1'b0;
                w_nxt_state    = S_RESULT;
                if (w_is_nan) begin
                    w_nxt_acc      = '0;
                    w_nxt_inv_pend = 1'b1;
                end else if (w_is_inf) begin
                    w_nxt_acc      = w_sat_mag;
                    w_nxt_ovf_pend = 1'b1;
                end else if (w_is_zero) begin
                    w_nxt_acc = '0;
                end else if (w_is_normal && (w_k >= K_LIMIT)) begin
                    w_nxt_acc      = w_sat_mag;
                    w_nxt_ovf_pend = 1'b1;
                end else if (w_k <= -8'sd11) begin
                    // Every mantissa bit is shifted out below the LSB.
                    w_nxt_acc = '0;
                end else if (w_k == 8'sd0) begin
                    w_nxt_acc = w_mant_ext;
                end else begin
                    w_nxt_acc      = w_mant_ext;
                    w_nxt_cnt      = w_abs_k;
                    w_nxt_dir_left = ~w_k[7];
                    w_nxt_state    = S_SHIFT;
                end
            end
            S_SHIFT: begin
                w_nxt_acc = r_dir_left ? (r_acc << 1) : (r_acc >> 1);
                w_nxt_cnt = r_cnt - 8'd1;
                if (r_cnt == 8'd1) begin
                    w_nxt_state = S_RESULT;
                end
            end
            S_RESULT: begin
                w_nxt_fixed = w_sign ? -r_acc : r_acc;
                w_nxt_ovf   = r_ovf_pend;
                w_nxt_inv   = r_inv_pend;
                w_nxt_done  = 1'b1;
                w_nxt_state = S_IDLE;
            end
            default: begin
                w_nxt_state = S_IDLE;
            end
        endcase
    end

    assign bus.fixed_out = r_fixed;
    assign bus.done      = r_done;
    assign bus.busy      = (r_state != S_IDLE);
    assign bus.overflow  = r_ovf;
    assign bus.invalid   = r_inv;

endmodule

// File: tb/tb_fp16_to_fixed.sv
// Self-checking bench for fp16_to_fixed at N=32, Q=23.
// Expected results are queued when a start is driven and compared when done pulses.
// Bounded waits throughout; a missing done counts as an error.
module tb_fp16_to_fixed;

    logic clk;
    logic rst_n;
    int   cyc;
    int   checks;
    int   errors;

    fp16_to_fixed_if #(.N(32)) bus ();

    fp16_to_fixed #(.N(32), .Q(23)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [15:0] f;
        logic [31:0] x;
        logic        ov;
        logic        inv;
        int          lat;
    } vec_t;

    typedef struct {
        logic [15:0] f;
        logic [31:0] x;
        logic        ov;
        logic        inv;
        int          done_cyc;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    logic prev_done;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard consumer: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && bus.done) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done=1 expected no pending request (t=%0t)", $time);
            end else begin
                e = sb.pop_front();
                chk($sformatf("fixed_out[%04h]", e.f), bus.fixed_out, e.x);
                chk($sformatf("overflow[%04h]", e.f), 32'(bus.overflow), 32'(e.ov));
                chk($sformatf("invalid[%04h]", e.f), 32'(bus.invalid), 32'(e.inv));
                chk($sformatf("done_cycle[%04h]", e.f), 32'(cyc), 32'(e.done_cyc));
                chk($sformatf("busy_at_done[%04h]", e.f), 32'(bus.busy), 32'd0);
            end
        end
        if (rst_n && prev_done) begin
            chk("done_single_cycle", 32'(bus.done), 32'd0);
        end
        prev_done <= bus.done;
    end

    task automatic wait_drain(input string name);
        for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge clk);
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL timeout_%s: got %0d pending results expected 0", name, sb.size());
            sb.delete();
        end
    endtask

    // Pulse start for one cycle and queue the expected result; done lands lat edges after accept.
    task automatic issue(input logic [15:0] f, input logic [31:0] x, input logic ov,
                         input logic inv, input int lat);
        exp_t e;
        bus.float_in = f;
        bus.start    = 1'b1;
        e.f = f; e.x = x; e.ov = ov; e.inv = inv; e.done_cyc = cyc + 1 + lat;
        sb.push_back(e);
        @(negedge clk);
        bus.start = 1'b0;
        chk($sformatf("busy_after_accept[%04h]", f), 32'(bus.busy), 32'd1);
    endtask

    initial begin
        checks       = 0;
        errors       = 0;
        cyc          = 0;
        prev_done    = 1'b0;
        rst_n        = 1'b0;
        bus.start    = 1'b0;
        bus.float_in = 16'h0000;

        vecs.push_back('{16'h3C00, 32'h00800000, 1'b0, 1'b0, 15}); // 1.0
        vecs.push_back('{16'hC100, 32'hFEC00000, 1'b0, 1'b0, 16}); // -2.5
        vecs.push_back('{16'h0400, 32'h00000200, 1'b0, 1'b0, 3});  // 2^-14
        vecs.push_back('{16'h5C00, 32'h7FFFFFFF, 1'b1, 1'b0, 2});  // 256 saturates
        vecs.push_back('{16'hFC00, 32'h80000000, 1'b1, 1'b0, 2});  // -inf
        vecs.push_back('{16'h7C00, 32'h7FFFFFFF, 1'b1, 1'b0, 2});  // +inf
        vecs.push_back('{16'h7E00, 32'h00000000, 1'b0, 1'b1, 2});  // NaN
        vecs.push_back('{16'hFE00, 32'h00000000, 1'b0, 1'b1, 2});  // negative NaN
        vecs.push_back('{16'h0000, 32'h00000000, 1'b0, 1'b0, 2});  // +0
        vecs.push_back('{16'h8000, 32'h00000000, 1'b0, 1'b0, 2});  // -0
        vecs.push_back('{16'h0001, 32'h00000000, 1'b0, 1'b0, 3});  // 2^-24 truncates
        vecs.push_back('{16'h0003, 32'h00000001, 1'b0, 1'b0, 3});
        vecs.push_back('{16'h0200, 32'h00000100, 1'b0, 1'b0, 3});  // subnormal 2^-15
        vecs.push_back('{16'h0800, 32'h00000400, 1'b0, 1'b0, 2});  // k=0 shortcut
        vecs.push_back('{16'h3555, 32'h002AA800, 1'b0, 1'b0, 13});
        vecs.push_back('{16'h5BFF, 32'h7FF00000, 1'b0, 1'b0, 22}); // largest non-saturating
        vecs.push_back('{16'hDBFF, 32'h80100000, 1'b0, 1'b0, 22});

        repeat (3) @(negedge clk);
        chk("reset_fixed_out", bus.fixed_out, 32'h0);
        chk("reset_flags", {29'd0, bus.done, bus.overflow, bus.invalid}, 32'h0);
        chk("reset_busy", 32'(bus.busy), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        foreach (vecs[i]) begin
            issue(vecs[i].f, vecs[i].x, vecs[i].ov, vecs[i].inv, vecs[i].lat);
            wait_drain($sformatf("vec%0d", i));
            @(negedge clk);
        end

        // Second start while busy must be ignored without resampling float_in.
        issue(16'h3C00, 32'h00800000, 1'b0, 1'b0, 15);
        @(negedge clk);
        bus.float_in = 16'h5C00;
        bus.start    = 1'b1;
        @(negedge clk);
        bus.start    = 1'b0;
        wait_drain("busy_ignore");
        repeat (20) @(negedge clk);

        // Start coincident with done is accepted and yields its own result.
        issue(16'h3C00, 32'h00800000, 1'b0, 1'b0, 15);
        begin
            int n;
            n = 0;
            while (!bus.done && n < 40) begin
                @(negedge clk);
                n++;
            end
            chk("coincident_done_seen", 32'(bus.done), 32'd1);
            issue(16'h4000, 32'h01000000, 1'b0, 1'b0, 16);
        end
        wait_drain("coincident");
        repeat (2) @(negedge clk);

        // Reset mid-shift discards the conversion and clears all outputs.
        issue(16'h3C00, 32'h00800000, 1'b0, 1'b0, 15);
        repeat (4) @(negedge clk);
        sb.delete();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("rst_mid_fixed_out", bus.fixed_out, 32'h0);
        chk("rst_mid_flags", {29'd0, bus.done, bus.overflow, bus.invalid}, 32'h0);
        chk("rst_mid_busy", 32'(bus.busy), 32'd0);
        repeat (25) @(negedge clk);
        issue(16'h4000, 32'h01000000, 1'b0, 1'b0, 16);
        wait_drain("after_reset");
        repeat (3) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
